// File: rtl/id_decode_stage_pkg.sv
// Shared pipeline definitions: opcodes, control-word layout and encodings.
package id_decode_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int CTRL_W    = 12;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b11
    } mem_size_e;

    // Field order fixes the bit map: reg_dst is bit 11, mem_size is [1:0]
    typedef struct packed {
        logic      reg_dst;
        logic      alu_src;
        logic      mem_to_reg;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      mem_unsigned;
        alu_op_e   alu_op;
        mem_size_e mem_size;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    // Opcode to control word; unknown opcodes decode as a bubble
    function automatic ctrl_word_t decode_ctrl(input logic [5:0] opcode);
        ctrl_word_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                c.alu_src      = 1'b1;
                c.mem_to_reg   = 1'b1;
                c.reg_write    = 1'b1;
                c.mem_read     = 1'b1;
                c.mem_unsigned = (opcode == OP_LBU) || (opcode == OP_LHU);
                if (opcode == OP_LW)
                    c.mem_size = MEM_WORD;
                else if ((opcode == OP_LH) || (opcode == OP_LHU))
                    c.mem_size = MEM_HALF;
                else
                    c.mem_size = MEM_BYTE;
            end
            OP_SB, OP_SH, OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                if (opcode == OP_SW)
                    c.mem_size = MEM_WORD;
                else if (opcode == OP_SH)
                    c.mem_size = MEM_HALF;
                else
                    c.mem_size = MEM_BYTE;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.alu_op    = ALU_IMM;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_decode_stage_register_file.sv
// 32x32 register file: one synchronous write port, two combinational read
// ports with write-through bypass, and a flat dump of the raw array.
module id_decode_stage_register_file
    import id_decode_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [REG_IDX_W-1:0]         wa,
    input  logic [DATA_W-1:0]            wd,
    input  logic [REG_IDX_W-1:0]         ra1,
    input  logic [REG_IDX_W-1:0]         ra2,
    output logic [DATA_W-1:0]            rd1,
    output logic [DATA_W-1:0]            rd2,
    output logic [NUM_REGS*DATA_W-1:0]   dump
);

    logic [DATA_W-1:0] regs_reg [NUM_REGS];

    // Array clears on reset; otherwise the write port updates one entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_reg[i] <= '0;
        end else if (we) begin
            regs_reg[wa] <= wd;
        end
    end

    // A write in flight is forwarded so the same-edge latch sees the new value
    assign rd1 = (we && (ra1 == wa)) ? wd : regs_reg[ra1];
    assign rd2 = (we && (ra2 == wa)) ? wd : regs_reg[ra2];

    // Debug dump shows stored contents only, never the bypass
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dump
            assign dump[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/id_decode_stage.sv
// ID stage: operand read, immediate sign extension, control decode and the
// ID/EX pipeline register.
module id_decode_stage
    import id_decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          stop,
    input  logic          reg_write_in,
    input  logic [31:0]   instruccion,
    input  logic [4:0]    WR,
    input  logic [31:0]   WD,
    output logic [31:0]   data1,
    output logic [31:0]   data2,
    output logic [31:0]   ext_sig,
    output logic [11:0]   palabra_salida,
    output logic [1023:0] registros
);

    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext_next;
    ctrl_word_t  ctrl_next;

    id_decode_stage_register_file u_register_file (
        .clk  (clk),
        .rst  (rst),
        .we   (reg_write_in),
        .wa   (WR),
        .wd   (WD),
        .ra1  (instruccion[25:21]),
        .ra2  (instruccion[20:16]),
        .rd1  (rd1),
        .rd2  (rd2),
        .dump (registros)
    );

    // Decode control word and sign-extended immediate from the raw instruction
    always_comb begin
        ctrl_next = decode_ctrl(instruccion[31:26]);
        ext_next  = {{16{instruccion[15]}}, instruccion[15:0]};
    end

    // ID/EX register: hold when disabled, bubble clears only the control word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data1          <= '0;
            data2          <= '0;
            ext_sig        <= '0;
            palabra_salida <= '0;
        end else if (ena) begin
            data1          <= rd1;
            data2          <= rd2;
            ext_sig        <= ext_next;
            palabra_salida <= stop ? CTRL_NOP : ctrl_next;
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed steps followed by randomized traffic,
// each edge checked against a behavioural model of the ID stage.
module tb_id_decode_stage;

    logic          clk;
    logic          rst;
    logic          ena;
    logic          stop;
    logic          reg_write_in;
    logic [31:0]   instruccion;
    logic [4:0]    WR;
    logic [31:0]   WD;
    logic [31:0]   data1;
    logic [31:0]   data2;
    logic [31:0]   ext_sig;
    logic [11:0]   palabra_salida;
    logic [1023:0] registros;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_d1, m_d2, m_ext;
    logic [11:0] m_ctrl;

    id_decode_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .stop           (stop),
        .reg_write_in   (reg_write_in),
        .instruccion    (instruccion),
        .WR             (WR),
        .WD             (WD),
        .data1          (data1),
        .data2          (data2),
        .ext_sig        (ext_sig),
        .palabra_salida (palabra_salida),
        .registros      (registros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word table from the opcode list
    function automatic logic [11:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00: return 12'h908;
            6'h20: return 12'h780;
            6'h21: return 12'h781;
            6'h23: return 12'h783;
            6'h24: return 12'h790;
            6'h25: return 12'h791;
            6'h28: return 12'h440;
            6'h29: return 12'h441;
            6'h2B: return 12'h443;
            6'h04: return 12'h024;
            6'h08: return 12'h500;
            6'h0C, 6'h0D, 6'h0A: return 12'h50C;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [1023:0] model_flat();
        logic [1023:0] f;
        for (int i = 0; i < 32; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_d1 = '0; m_d2 = '0; m_ext = '0; m_ctrl = '0;
    endtask

    // One rising edge as seen by the model, using the inputs currently driven
    task automatic model_edge();
        logic [4:0] rs, rt;
        rs = instruccion[25:21];
        rt = instruccion[20:16];
        if (ena) begin
            m_d1   = (reg_write_in && WR == rs) ? WD : m_regs[rs];
            m_d2   = (reg_write_in && WR == rt) ? WD : m_regs[rt];
            m_ext  = {{16{instruccion[15]}}, instruccion[15:0]};
            m_ctrl = stop ? 12'h000 : ref_ctrl(instruccion[31:26]);
        end
        if (reg_write_in) m_regs[WR] = WD;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_file(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk32({tag, "_data1"}, data1, m_d1);
        chk32({tag, "_data2"}, data2, m_d2);
        chk32({tag, "_ext"},   ext_sig, m_ext);
        chk32({tag, "_ctrl"},  {20'd0, palabra_salida}, {20'd0, m_ctrl});
        chk_file({tag, "_regs"}, registros, model_flat());
    endtask

    // Drive inputs, take one edge, update model, then check 1 ns later
    task automatic step(input logic e, input logic s, input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [31:0] ins, input string tag);
        ena = e; stop = s; reg_write_in = we; WR = wr; WD = wd; instruccion = ins;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        $display("step %s: ena=%0b stop=%0b we=%0b WR=%0d WD=%h instr=%h -> d1=%h d2=%h ext=%h ctrl=%h",
                 tag, e, s, we, wr, wd, ins, data1, data2, ext_sig, palabra_salida);
    endtask

    initial begin
        logic [5:0]  ops [16];
        logic [31:0] r;
        logic [5:0]  op;
        ops = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29,
                6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F, 6'h02};

        rst = 1'b1; ena = 1'b0; stop = 1'b0; reg_write_in = 1'b0;
        WR = '0; WD = '0; instruccion = '0;
        model_reset();
        #22;
        check_all("reset");
        $display("reset held: outputs and register file checked");

        @(negedge clk);
        rst = 1'b0;

        // Directed sequence
        step(1, 0, 1, 5'd0, 32'hAAAAAAAA, 32'h00000001, "rtype_bypass");
        chk32("tp1_data1", data1, 32'hAAAAAAAA);
        chk32("tp1_ctrl", {20'd0, palabra_salida}, 32'h908);
        step(1, 0, 1, 5'd1, 32'h55555555, 32'h80010001, "lb");
        chk32("tp2_reg1", registros[63:32], 32'h55555555);
        chk32("tp2_ctrl", {20'd0, palabra_salida}, 32'h780);
        step(1, 0, 0, 5'd2, 32'h12345678, 32'hA0000001, "sb");
        chk32("tp3_ctrl", {20'd0, palabra_salida}, 32'h440);
        step(1, 0, 0, 5'd2, 32'h12345678, 32'h10000001, "beq");
        chk32("tp4_ctrl", {20'd0, palabra_salida}, 32'h024);
        step(1, 0, 0, 5'd0, 32'h0, 32'h2000FFFF, "addi");
        chk32("tp5_ext", ext_sig, 32'hFFFFFFFF);
        chk32("tp5_ctrl", {20'd0, palabra_salida}, 32'h500);
        step(1, 1, 0, 5'd0, 32'h0, 32'h2000FFFF, "addi_stop");
        chk32("tp6_ctrl", {20'd0, palabra_salida}, 32'h000);
        step(0, 0, 1, 5'd5, 32'hDEADBEEF, 32'h00A50123, "hold_write5");
        chk32("tp7_reg5", registros[191:160], 32'hDEADBEEF);
        chk32("tp7_ctrl_hold", {20'd0, palabra_salida}, 32'h000);
        step(1, 0, 0, 5'd0, 32'h0, 32'h34A51234, "ori_read5");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 15)];
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
                 $urandom(), {op, r[25:0]}, "rand");
        end

        // Asynchronous reset between edges
        step(1, 0, 1, 5'd7, 32'hCAFEF00D, 32'h00E70007, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        $display("async reset mid-cycle: outputs and register file checked");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 15)];
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)),
                 $urandom(), {op, r[25:0]}, "rand_post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
